// File: rtl/mips_defs.sv
// Shared MIPS encodings for the pipeline: opcode/funct values, the link
// register index and the write-back data-source code.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_BLEZALS = 6'b011000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUBU    = 6'b100011;

  localparam logic [4:0] REG_RA     = 5'd31;

  // Which registered value feeds the register-file write port.
  typedef enum logic [1:0] {
    WB_SRC_ALU = 2'd0,
    WB_SRC_MEM = 2'd1,
    WB_SRC_PC8 = 2'd2
  } wb_src_e;

endpackage

// File: rtl/level_writeback_decode.sv
// Write-back decode: from a registered instruction, derive whether it writes
// the register file, which register, and where the data comes from.
module wb_decode
  import mips_defs::*;
(
  input  logic [31:0] instr,
  input  logic        link_en,
  output logic        dec_write,
  output logic [4:0]  dest,
  output logic [1:0]  wb_src
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];

  // rs and shamt never influence the write-back destination.
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    dec_write = 1'b0;
    dest      = 5'd0;
    wb_src    = WB_SRC_ALU;
    case (opcode)
      OP_ORI, OP_LUI: begin
        dec_write = 1'b1;
        dest      = rt;
      end
      OP_LW: begin
        dec_write = 1'b1;
        dest      = rt;
        wb_src    = WB_SRC_MEM;
      end
      OP_SPECIAL: begin
        if (funct == FN_ADDU || funct == FN_SUBU) begin
          dec_write = 1'b1;
          dest      = rd;
        end
      end
      OP_JAL: begin
        dec_write = 1'b1;
        dest      = REG_RA;
        wb_src    = WB_SRC_PC8;
      end
      // The link condition was resolved upstream and travels with the slot.
      OP_BLEZALS: begin
        dec_write = link_en;
        dest      = REG_RA;
        wb_src    = WB_SRC_PC8;
      end
      default: begin
        dec_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/level_writeback.sv
// MEM/WB pipeline register and write-back stage: registers the memory-stage
// slot, drives the register-file write port, the forwarding select and a
// retired-instruction counter.
module level_writeback
  import mips_defs::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             valid_in,
  input  logic [31:0]      Instr_in,
  input  logic [31:0]      pc_add_4_in,
  input  logic [31:0]      pc_add_8_in,
  input  logic [31:0]      ALUResult_in,
  input  logic [31:0]      DM_data_in,
  input  logic             link_en_in,
  output logic [31:0]      Instr_W,
  output logic [31:0]      pc_add_4_W,
  output logic             valid_W,
  output logic             RegWrite_W,
  output logic [4:0]       RegAddr_W,
  output logic [31:0]      RegData_W,
  output logic [4:0]       select_Writedata,
  output logic [CNT_W-1:0] retire_count
);

  // Pipeline control: the register loads the memory-stage slot on every edge
  // unless stalled; flush overrides stall and loads an empty slot. A slot is
  // only an instruction when valid is set, and only loads of valid slots retire.
  logic [31:0]      instr_q;
  logic [31:0]      pc4_q;
  logic [31:0]      pc8_q;
  logic [31:0]      alu_q;
  logic [31:0]      dm_q;
  logic             valid_q;
  logic             link_q;
  logic [CNT_W-1:0] retire_q;

  logic             load_en;
  logic             dec_write;
  logic [4:0]       dec_dest;
  logic [1:0]       dec_src;
  logic             reg_write;
  logic [31:0]      wb_data;

  assign load_en = !flush && !stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      pc8_q   <= 32'd0;
      alu_q   <= 32'd0;
      dm_q    <= 32'd0;
      valid_q <= 1'b0;
      link_q  <= 1'b0;
    end else if (flush) begin
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      pc8_q   <= 32'd0;
      alu_q   <= 32'd0;
      dm_q    <= 32'd0;
      valid_q <= 1'b0;
      link_q  <= 1'b0;
    end else if (!stall) begin
      instr_q <= Instr_in;
      pc4_q   <= pc_add_4_in;
      pc8_q   <= pc_add_8_in;
      alu_q   <= ALUResult_in;
      dm_q    <= DM_data_in;
      valid_q <= valid_in;
      link_q  <= link_en_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else if (load_en && valid_in) begin
      retire_q <= retire_q + CNT_W'(1);
    end
  end

  wb_decode u_decode (
    .instr     (instr_q),
    .link_en   (link_q),
    .dec_write (dec_write),
    .dest      (dec_dest),
    .wb_src    (dec_src)
  );

  // Writes to $0 are dropped so forwarding never matches the zero register.
  assign reg_write = valid_q && dec_write && (dec_dest != 5'd0);

  always_comb begin
    wb_data = alu_q;
    case (dec_src)
      WB_SRC_MEM: wb_data = dm_q;
      WB_SRC_PC8: wb_data = pc8_q;
      default:    wb_data = alu_q;
    endcase
  end

  assign Instr_W      = instr_q;
  assign pc_add_4_W   = pc4_q;
  assign valid_W      = valid_q;
  assign RegWrite_W   = reg_write;
  assign RegAddr_W    = reg_write ? dec_dest : 5'd0;
  assign RegData_W    = reg_write ? wb_data : 32'd0;
  assign retire_count = retire_q;

  // Memory stage stores rt; it should take W-stage data when W writes that rt.
  assign select_Writedata = {4'b0000,
                             reg_write && (dec_dest == Instr_in[20:16]) &&
                             (Instr_in[20:16] != 5'd0)};

endmodule

// File: tb/tb_level_writeback.sv
// Self-checking bench for level_writeback: directed and random slots through a
// scoreboard, stall/flush, async reset and counter wrap on a narrow instance.
module tb_level_writeback;

  localparam int EW = 32 + 32 + 1 + 1 + 5 + 32;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid_in;
  logic [31:0] Instr_in;
  logic [31:0] pc_add_4_in;
  logic [31:0] pc_add_8_in;
  logic [31:0] ALUResult_in;
  logic [31:0] DM_data_in;
  logic        link_en_in;

  logic [31:0] Instr_W;
  logic [31:0] pc_add_4_W;
  logic        valid_W;
  logic        RegWrite_W;
  logic [4:0]  RegAddr_W;
  logic [31:0] RegData_W;
  logic [4:0]  select_Writedata;
  logic [31:0] retire_count;

  logic [31:0] n_instr;
  logic [31:0] n_pc4;
  logic        n_valid;
  logic        n_we;
  logic [4:0]  n_addr;
  logic [31:0] n_data;
  logic [4:0]  n_sel;
  logic [2:0]  n_count;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   cnt_q[$];

  int          n_cmp;
  int          n_err;
  logic [31:0] cnt_model;
  logic [EW-1:0] last_exp;

  level_writeback #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .Instr_in(Instr_in), .pc_add_4_in(pc_add_4_in), .pc_add_8_in(pc_add_8_in),
    .ALUResult_in(ALUResult_in), .DM_data_in(DM_data_in), .link_en_in(link_en_in),
    .Instr_W(Instr_W), .pc_add_4_W(pc_add_4_W), .valid_W(valid_W),
    .RegWrite_W(RegWrite_W), .RegAddr_W(RegAddr_W), .RegData_W(RegData_W),
    .select_Writedata(select_Writedata), .retire_count(retire_count)
  );

  level_writeback #(.CNT_W(3)) dut_narrow (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_in(valid_in),
    .Instr_in(Instr_in), .pc_add_4_in(pc_add_4_in), .pc_add_8_in(pc_add_8_in),
    .ALUResult_in(ALUResult_in), .DM_data_in(DM_data_in), .link_en_in(link_en_in),
    .Instr_W(n_instr), .pc_add_4_W(n_pc4), .valid_W(n_valid),
    .RegWrite_W(n_we), .RegAddr_W(n_addr), .RegData_W(n_data),
    .select_Writedata(n_sel), .retire_count(n_count)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected finish before 200000");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Driver: present a slot at negedge, push its expected WB view, compare after the edge.
  task automatic drive(input logic [31:0] instr, alu, dm, pc8, input logic link, v, st, fl,
                       input logic [EW-1:0] e, input logic [31:0] e_cnt);
    logic [EW-1:0] got_e;
    logic [31:0]   got_c;
    @(negedge clk);
    Instr_in     = instr;
    ALUResult_in = alu;
    DM_data_in   = dm;
    pc_add_8_in  = pc8;
    pc_add_4_in  = pc8 - 32'd4;
    link_en_in   = link;
    valid_in     = v;
    stall        = st;
    flush        = fl;
    exp_q.push_back(e);
    cnt_q.push_back(e_cnt);
    @(posedge clk);
    #1;
    got_e = exp_q.pop_front();
    got_c = cnt_q.pop_front();
    check("instr_w",  Instr_W,               got_e[102:71]);
    check("pc4_w",    pc_add_4_W,            got_e[70:39]);
    check("valid_w",  {31'd0, valid_W},      {31'd0, got_e[38]});
    check("regwrite", {31'd0, RegWrite_W},   {31'd0, got_e[37]});
    check("regaddr",  {27'd0, RegAddr_W},    {27'd0, got_e[36:32]});
    check("regdata",  RegData_W,             got_e[31:0]);
    check("retire",   retire_count,          got_c);
    check("retire_n", {29'd0, n_count},      {29'd0, got_c[2:0]});
    last_exp = got_e;
  endtask

  // Normal load of a valid slot; caller states the expected write port.
  task automatic ld(input logic [31:0] instr, alu, dm, pc8, input logic link,
                    input logic we, input logic [4:0] addr, input logic [31:0] data);
    cnt_model = cnt_model + 32'd1;
    drive(instr, alu, dm, pc8, link, 1'b1, 1'b0, 1'b0,
          {instr, pc8 - 32'd4, 1'b1, we, addr, data}, cnt_model);
  endtask

  task automatic chk_sel(input logic [4:0] rt, input logic [4:0] exp_sel);
    Instr_in = i_type(6'b101011, 5'd29, rt, 16'h0004);
    #1;
    check("select_wd", {27'd0, select_Writedata}, {27'd0, exp_sel});
  endtask

  initial begin
    logic [31:0] instr, alu, dm;
    logic [4:0]  rs, rt, rd, dest;
    logic [31:0] data;
    int          kind;

    n_cmp = 0;
    n_err = 0;
    cnt_model = 32'd0;
    last_exp = '0;
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    valid_in = 1'b0;
    Instr_in = 32'd0;
    pc_add_4_in = 32'd0;
    pc_add_8_in = 32'd0;
    ALUResult_in = 32'd0;
    DM_data_in = 32'd0;
    link_en_in = 1'b0;

    #12;
    check("rst_valid",  {31'd0, valid_W},    32'd0);
    check("rst_instr",  Instr_W,             32'd0);
    check("rst_regwr",  {31'd0, RegWrite_W}, 32'd0);
    check("rst_data",   RegData_W,           32'd0);
    check("rst_retire", retire_count,        32'd0);
    @(negedge clk);
    reset = 1'b1;

    // addu $3,$1,$2
    ld(r_type(5'd1, 5'd2, 5'd3, 6'b100001), 32'h0000_0005, 32'h1111_1111, 32'h0000_1008,
       1'b0, 1'b1, 5'd3, 32'h0000_0005);
    // lw $8, 16($29), then forwarding to a store of rt=8 / rt=9
    ld(i_type(6'b100011, 5'd29, 5'd8, 16'h0010), 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_100C,
       1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    chk_sel(5'd8, 5'd1);
    chk_sel(5'd9, 5'd0);
    // jal, blezals not taken / taken
    ld({6'b000011, 26'h000_0C03}, 32'h0000_0077, 32'h0, 32'h0000_300C,
       1'b0, 1'b1, 5'd31, 32'h0000_300C);
    chk_sel(5'd31, 5'd1);
    ld(i_type(6'b011000, 5'd4, 5'd0, 16'h0003), 32'h0000_0099, 32'h0, 32'h0000_4010,
       1'b0, 1'b0, 5'd0, 32'h0);
    ld(i_type(6'b011000, 5'd4, 5'd0, 16'h0003), 32'h0000_0099, 32'h0, 32'h0000_4020,
       1'b1, 1'b1, 5'd31, 32'h0000_4020);
    // ori $0,$0,5 and non-writers
    ld(i_type(6'b001101, 5'd0, 5'd0, 16'h0005), 32'h0000_0005, 32'h0, 32'h0000_5008,
       1'b0, 1'b0, 5'd0, 32'h0);
    chk_sel(5'd0, 5'd0);
    ld(i_type(6'b101011, 5'd2, 5'd7, 16'h0020), 32'h0000_0040, 32'hABCD_0000, 32'h0000_500C,
       1'b0, 1'b0, 5'd0, 32'h0);
    ld(i_type(6'b000100, 5'd2, 5'd7, 16'h0020), 32'h0000_0041, 32'h0, 32'h0000_5010,
       1'b0, 1'b0, 5'd0, 32'h0);
    ld(i_type(6'b001111, 5'd0, 5'd12, 16'h1234), 32'h1234_0000, 32'h0, 32'h0000_5014,
       1'b0, 1'b1, 5'd12, 32'h1234_0000);
    ld(r_type(5'd9, 5'd10, 5'd7, 6'b100011), 32'hFFFF_FFF0, 32'h0, 32'h0000_5018,
       1'b0, 1'b1, 5'd7, 32'hFFFF_FFF0);

    // addu $5 loaded, held through two stall edges, then stall+flush
    ld(r_type(5'd1, 5'd2, 5'd5, 6'b100001), 32'h0000_00A5, 32'h0, 32'h0000_6008,
       1'b0, 1'b1, 5'd5, 32'h0000_00A5);
    for (int i = 0; i < 2; i++) begin
      drive(r_type(5'd3, 5'd4, 5'd6, 6'b100001), 32'h0BAD_0000, 32'h0, 32'h0000_7008,
            1'b0, 1'b1, 1'b1, 1'b0, last_exp, cnt_model);
    end
    drive(r_type(5'd3, 5'd4, 5'd6, 6'b100001), 32'h0BAD_0000, 32'h0, 32'h0000_7008,
          1'b0, 1'b1, 1'b1, 1'b1, '0, cnt_model);
    ld(r_type(5'd1, 5'd2, 5'd6, 6'b100001), 32'h0000_00A6, 32'h0, 32'h0000_700C,
       1'b0, 1'b1, 5'd6, 32'h0000_00A6);
    drive(r_type(5'd3, 5'd4, 5'd7, 6'b100001), 32'h0BAD_0001, 32'h0, 32'h0000_7010,
          1'b0, 1'b1, 1'b0, 1'b1, '0, cnt_model);
    // invalid slot loads but neither writes nor retires
    drive(r_type(5'd3, 5'd4, 5'd7, 6'b100001), 32'h0000_0123, 32'h0, 32'h0000_7014,
          1'b0, 1'b0, 1'b0, 1'b0,
          {r_type(5'd3, 5'd4, 5'd7, 6'b100001), 32'h0000_7010, 1'b0, 1'b0, 5'd0, 32'h0},
          cnt_model);

    // random addu / lw / ori with spec-level expectations
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 2);
      rs = 5'($urandom_range(0, 31));
      rt = 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      if (i % 6 == 0) begin
        rt = 5'd0;
        rd = 5'd0;
      end
      alu = $urandom;
      dm  = $urandom;
      if (kind == 0) begin
        instr = r_type(rs, rt, rd, 6'b100001);
        dest  = rd;
        data  = alu;
      end else if (kind == 1) begin
        instr = i_type(6'b100011, rs, rt, 16'($urandom));
        dest  = rt;
        data  = dm;
      end else begin
        instr = i_type(6'b001101, rs, rt, 16'($urandom));
        dest  = rt;
        data  = alu;
      end
      ld(instr, alu, dm, 32'h0000_8000 + 32'(i * 4), 1'b0, dest != 5'd0,
         (dest != 5'd0) ? dest : 5'd0, (dest != 5'd0) ? data : 32'h0);
    end

    // asynchronous reset between edges while valid_W=1
    ld(r_type(5'd1, 5'd2, 5'd3, 6'b100001), 32'h0000_0055, 32'h0, 32'h0000_9008,
       1'b0, 1'b1, 5'd3, 32'h0000_0055);
    stall = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid",  {31'd0, valid_W},    32'd0);
    check("arst_instr",  Instr_W,             32'd0);
    check("arst_pc4",    pc_add_4_W,          32'd0);
    check("arst_regwr",  {31'd0, RegWrite_W}, 32'd0);
    check("arst_addr",   {27'd0, RegAddr_W},  32'd0);
    check("arst_data",   RegData_W,           32'd0);
    check("arst_retire", retire_count,        32'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt_model = 32'd0;

    // eight retirements: the 3-bit counter wraps from 7 to 0
    for (int i = 0; i < 8; i++) begin
      ld(r_type(5'd1, 5'd2, 5'd4, 6'b100001), 32'(i + 1), 32'h0, 32'h0000_A000 + 32'(i * 4),
         1'b0, 1'b1, 5'd4, 32'(i + 1));
    end
    check("wrap_narrow", {29'd0, n_count}, 32'd0);
    check("wrap_wide",   retire_count,     32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
